// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared state encoding and limits for the layer sequencer
package nn_pkg;

  localparam int STAGE_W     = 3;
  localparam int CLASS_W_DEF = 4;
  localparam int MAX_LAYERS  = 16;

  typedef enum logic [STAGE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_MM     = 3'd1,
    ST_RELU   = 3'd2,
    ST_ARGMAX = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  // Stages during which an engine is running and the watchdog/latency counters advance
  function automatic logic is_busy(input state_t s);
    return (s == ST_MM) || (s == ST_RELU) || (s == ST_ARGMAX);
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// rtl/stage_watchdog.sv - per-stage cycle counter with timeout flag
module stage_watchdog #(
  parameter int TIMEOUT = 2_000_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int            CW    = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Count cycles spent in the current stage; parks at the limit once reached
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !timeout) begin
      count <= count + CW'(1);
    end
  end

  assign timeout = enable && (count == LIMIT);

endmodule

// File: rtl/nn_layer_sequencer.sv
// rtl/nn_layer_sequencer.sv - MM/ReLU/argmax stage sequencer with watchdog and latency counter
module nn_layer_sequencer
  import nn_pkg::*;
#(
  parameter int                    NUM_LAYERS = 4,
  parameter logic [NUM_LAYERS-1:0] RELU_MASK  = 4'b0111,
  parameter int                    CLASS_W    = CLASS_W_DEF,
  parameter int                    TIMEOUT    = 2_000_000,
  localparam int                   LW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  output logic [NUM_LAYERS-1:0] mm_start,
  input  logic [NUM_LAYERS-1:0] mm_done,
  output logic [NUM_LAYERS-1:0] relu_start,
  input  logic [NUM_LAYERS-1:0] relu_done,
  output logic                  argmax_start,
  input  logic                  argmax_done,
  input  logic [CLASS_W-1:0]    argmax_index,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CLASS_W-1:0]    result,
  output logic [STAGE_W-1:0]    stage,
  output logic [LW-1:0]         layer,
  output logic [31:0]           cycles
);

  state_t                  state, state_next;
  logic [LW-1:0]           layer_next;
  logic [NUM_LAYERS-1:0]   mm_start_next, relu_start_next;
  logic                    argmax_start_next;
  logic                    enter;
  logic                    load_result;
  logic                    first_cycle;
  logic                    last_layer;
  logic                    timeout;

  stage_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (enter),
    .enable  (busy),
    .timeout (timeout)
  );

  assign last_layer = (layer == LW'(NUM_LAYERS - 1));

  // Next-state, next-layer and start-pulse selection; abort overrides everything
  always_comb begin
    state_next        = state;
    layer_next        = layer;
    mm_start_next     = '0;
    relu_start_next   = '0;
    argmax_start_next = 1'b0;
    enter             = 1'b0;
    load_result       = 1'b0;
    // The start pulse marks the entry cycle; engine done is not trusted until after it
    first_cycle       = (|mm_start) || (|relu_start) || argmax_start;

    if (abort) begin
      state_next = ST_IDLE;
      layer_next = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_next = ST_MM;
            layer_next = '0;
            enter      = 1'b1;
          end
        end
        ST_MM: begin
          if (!first_cycle && mm_done[layer]) begin
            enter = 1'b1;
            if (RELU_MASK[layer]) begin
              state_next = ST_RELU;
            end else if (last_layer) begin
              state_next = ST_ARGMAX;
            end else begin
              state_next = ST_MM;
              layer_next = layer + LW'(1);
            end
          end else if (timeout) begin
            state_next = ST_ERROR;
          end
        end
        ST_RELU: begin
          if (!first_cycle && relu_done[layer]) begin
            enter = 1'b1;
            if (last_layer) begin
              state_next = ST_ARGMAX;
            end else begin
              state_next = ST_MM;
              layer_next = layer + LW'(1);
            end
          end else if (timeout) begin
            state_next = ST_ERROR;
          end
        end
        ST_ARGMAX: begin
          if (!first_cycle && argmax_done) begin
            load_result = 1'b1;
            state_next  = ST_DONE;
          end else if (timeout) begin
            state_next = ST_ERROR;
          end
        end
        ST_DONE:  state_next = ST_IDLE;
        ST_ERROR: state_next = ST_ERROR;
        default: begin
          state_next = ST_IDLE;
          layer_next = '0;
        end
      endcase

      if (enter) begin
        case (state_next)
          ST_MM:     mm_start_next[layer_next]   = 1'b1;
          ST_RELU:   relu_start_next[layer_next] = 1'b1;
          ST_ARGMAX: argmax_start_next           = 1'b1;
          default:   ;
        endcase
      end
    end
  end

  // State, layer and registered one-cycle start pulses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      layer        <= '0;
      mm_start     <= '0;
      relu_start   <= '0;
      argmax_start <= 1'b0;
    end else begin
      state        <= state_next;
      layer        <= layer_next;
      mm_start     <= mm_start_next;
      relu_start   <= relu_start_next;
      argmax_start <= argmax_start_next;
    end
  end

  // Class index is captured only on a sampled argmax completion
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result <= '0;
    end else if (load_result) begin
      result <= argmax_index;
    end
  end

  // Latency from start acceptance, counting only engine-active cycles, saturating
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cycles <= '0;
    end else if (state == ST_IDLE && start && !abort) begin
      cycles <= '0;
    end else if (busy && !abort && cycles != 32'hFFFF_FFFF) begin
      cycles <= cycles + 32'd1;
    end
  end

  assign busy  = is_busy(state);
  assign done  = (state == ST_DONE);
  assign error = (state == ST_ERROR);
  assign stage = state;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb/tb_nn_layer_sequencer.sv - directed self-checking bench for nn_layer_sequencer
module tb_nn_layer_sequencer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start_m, start_n, abort;
  logic [3:0] mm_done, relu_done;
  logic       argmax_done;
  logic [3:0] argmax_index;

  logic [3:0]  mm_start_m, relu_start_m, result_m;
  logic        argmax_start_m, busy_m, done_m, error_m;
  logic [2:0]  stage_m;
  logic [1:0]  layer_m;
  logic [31:0] cycles_m;

  logic [3:0]  mm_start_n, relu_start_n, result_n;
  logic        argmax_start_n, busy_n, done_n, error_n;
  logic [2:0]  stage_n;
  logic [1:0]  layer_n;
  logic [31:0] cycles_n;

  int   n_vec = 0;
  int   n_err = 0;
  bit   sel = 1'b0;
  logic [8:0] pulse_obs;

  logic [8:0] seq_main [8] = '{9'h001, 9'h010, 9'h002, 9'h020, 9'h004, 9'h040, 9'h008, 9'h100};
  logic [8:0] seq_nr   [5] = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h100};

  always #5 clk = ~clk;

  nn_layer_sequencer #(
    .NUM_LAYERS (4),
    .RELU_MASK  (4'b0111),
    .CLASS_W    (4),
    .TIMEOUT    (16)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start_m),
    .abort        (abort),
    .mm_start     (mm_start_m),
    .mm_done      (mm_done),
    .relu_start   (relu_start_m),
    .relu_done    (relu_done),
    .argmax_start (argmax_start_m),
    .argmax_done  (argmax_done),
    .argmax_index (argmax_index),
    .busy         (busy_m),
    .done         (done_m),
    .error        (error_m),
    .result       (result_m),
    .stage        (stage_m),
    .layer        (layer_m),
    .cycles       (cycles_m)
  );

  nn_layer_sequencer #(
    .NUM_LAYERS (4),
    .RELU_MASK  (4'b0000),
    .CLASS_W    (4)
  ) dut_nr (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start_n),
    .abort        (abort),
    .mm_start     (mm_start_n),
    .mm_done      (mm_done),
    .relu_start   (relu_start_n),
    .relu_done    (relu_done),
    .argmax_start (argmax_start_n),
    .argmax_done  (argmax_done),
    .argmax_index (argmax_index),
    .busy         (busy_n),
    .done         (done_n),
    .error        (error_n),
    .result       (result_n),
    .stage        (stage_n),
    .layer        (layer_n),
    .cycles       (cycles_n)
  );

  always_comb pulse_obs = sel ? {argmax_start_n, relu_start_n, mm_start_n}
                              : {argmax_start_m, relu_start_m, mm_start_m};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_pulse(input string tag, input logic [8:0] exp, input int exp_wait);
    int w = 0;
    while (pulse_obs == 9'h000 && w < 20) begin
      step();
      w++;
    end
    check({tag, " pulse"}, {23'd0, pulse_obs}, {23'd0, exp});
    check({tag, " wait"}, w, exp_wait);
  endtask

  task automatic answer(input logic [8:0] exp);
    repeat (5) step();
    mm_done     = exp[3:0];
    relu_done   = exp[7:4];
    argmax_done = exp[8];
    step();
    mm_done     = '0;
    relu_done   = '0;
    argmax_done = 1'b0;
  endtask

  task automatic kick_main();
    start_m = 1'b1;
    step();
    start_m = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; start_m = 1'b0; start_n = 1'b0; abort = 1'b0;
    mm_done = '0; relu_done = '0; argmax_done = 1'b0; argmax_index = 4'd0;
    repeat (2) step();
    check("rst pulses", {23'd0, pulse_obs}, 32'd0);
    check("rst busy", busy_m, 1'b0);
    check("rst done", done_m, 1'b0);
    check("rst error", error_m, 1'b0);
    check("rst stage", stage_m, 3'd0);
    check("rst layer", layer_m, 2'd0);
    check("rst cycles", cycles_m, 32'd0);
    check("rst result", result_m, 4'd0);
    resetn = 1'b1;
    step();

    // Full default run: mm0 relu0 mm1 relu1 mm2 relu2 mm3 argmax, 6 cycles each
    kick_main();
    for (int i = 0; i < 8; i++) begin
      wait_pulse($sformatf("run stage%0d", i), seq_main[i], 0);
      if (i == 7) argmax_index = 4'd7;
      answer(seq_main[i]);
    end
    check("run done", done_m, 1'b1);
    check("run stage_done", stage_m, 3'd4);
    check("run result", result_m, 4'd7);
    check("run cycles", cycles_m, 32'd48);
    step();
    check("run done_drop", done_m, 1'b0);
    check("run idle", stage_m, 3'd0);
    check("run result_hold", result_m, 4'd7);

    // No-ReLU instance: argmax follows mm3 directly
    sel = 1'b1;
    start_n = 1'b1;
    step();
    start_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_pulse($sformatf("nr stage%0d", i), seq_nr[i], 0);
      if (i == 4) argmax_index = 4'hA;
      answer(seq_nr[i]);
    end
    check("nr done", done_n, 1'b1);
    check("nr result", result_n, 4'hA);
    check("nr cycles", cycles_n, 32'd30);
    check("nr main_idle", stage_m, 3'd0);
    check("nr main_result", result_m, 4'd7);
    step();
    sel = 1'b0;

    // Watchdog: mm_done[2] never arrives
    kick_main();
    for (int i = 0; i < 4; i++) begin
      wait_pulse($sformatf("to stage%0d", i), seq_main[i], 0);
      answer(seq_main[i]);
    end
    wait_pulse("to mm2", seq_main[4], 0);
    repeat (15) step();
    check("to still_mm", stage_m, 3'd1);
    check("to no_error_yet", error_m, 1'b0);
    step();
    check("to error", error_m, 1'b1);
    check("to stage", stage_m, 3'd5);
    check("to layer", layer_m, 2'd2);
    check("to busy", busy_m, 1'b0);
    repeat (5) step();
    check("to error_hold", error_m, 1'b1);
    do_abort();
    check("to abort_stage", stage_m, 3'd0);
    check("to abort_layer", layer_m, 2'd0);
    check("to abort_error", error_m, 1'b0);
    check("to abort_pulse", {23'd0, pulse_obs}, 32'd0);
    check("to cycles_hold", cycles_m, 32'd40);
    check("to result_hold", result_m, 4'd7);

    // Abort during layer-1 ReLU, then a late relu_done[1]
    kick_main();
    for (int i = 0; i < 3; i++) begin
      wait_pulse($sformatf("ab stage%0d", i), seq_main[i], 0);
      answer(seq_main[i]);
    end
    wait_pulse("ab relu1", seq_main[3], 0);
    repeat (2) step();
    do_abort();
    check("ab stage", stage_m, 3'd0);
    check("ab layer", layer_m, 2'd0);
    check("ab pulse", {23'd0, pulse_obs}, 32'd0);
    relu_done = 4'b0010;
    step();
    relu_done = 4'b0000;
    check("ab late_done_stage", stage_m, 3'd0);
    check("ab late_done_pulse", {23'd0, pulse_obs}, 32'd0);
    kick_main();
    check("ab restart_pulse", {23'd0, pulse_obs}, 32'h001);
    check("ab restart_stage", stage_m, 3'd1);
    do_abort();

    // Coincident mm_done[0] and spurious mm_done[3] are ignored
    kick_main();
    check("sp pulse", {23'd0, pulse_obs}, 32'h001);
    mm_done = 4'b1001;
    step();
    mm_done = 4'b1000;
    check("sp coincident_stage", stage_m, 3'd1);
    check("sp coincident_pulse", {23'd0, pulse_obs}, 32'd0);
    step();
    check("sp spurious_stage", stage_m, 3'd1);
    check("sp spurious_layer", layer_m, 2'd0);
    mm_done = 4'b0001;
    step();
    mm_done = 4'b0000;
    check("sp advance_pulse", {23'd0, pulse_obs}, 32'h010);
    check("sp advance_stage", stage_m, 3'd2);
    do_abort();

    // Asynchronous reset while in ARGMAX
    kick_main();
    for (int i = 0; i < 7; i++) begin
      wait_pulse($sformatf("rs stage%0d", i), seq_main[i], 0);
      answer(seq_main[i]);
    end
    wait_pulse("rs argmax", seq_main[7], 0);
    repeat (2) step();
    resetn = 1'b0;
    #1;
    check("rs pulses", {23'd0, pulse_obs}, 32'd0);
    check("rs busy", busy_m, 1'b0);
    check("rs stage", stage_m, 3'd0);
    check("rs cycles", cycles_m, 32'd0);
    check("rs result", result_m, 4'd0);
    check("rs done", done_m, 1'b0);
    step();
    resetn = 1'b1;
    argmax_done = 1'b1;
    step();
    argmax_done = 1'b0;
    check("rs late_stage", stage_m, 3'd0);
    check("rs late_done", done_m, 1'b0);
    check("rs late_result", result_m, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nn_layer_sequencer.md
# nn_layer_sequencer

- Parametrised control sequencer for the layered MNIST inference datapath: runs NUM_LAYERS matrix-multiply stages, each optionally followed by a ReLU stage, then one argmax stage.
- Successor to the fixed 4-layer top-level FSM, adding:
  - per-layer ReLU enable mask;
  - registered one-cycle start pulses;
  - a per-stage watchdog with error reporting;
  - abort;
  - a latched result;
  - a latency counter.
- Sits between the host/start logic and the per-layer engine instances; owns no memories and no arithmetic.

## Interface
Parameters:
- NUM_LAYERS, 4, number of MM stages (1..16)
- RELU_MASK, 4'b0111, bit i = 1 → ReLU stage follows MM layer i
- CLASS_W, 4, width of argmax result
- TIMEOUT, 2_000_000, max cycles allowed per stage before error (≥ 2)

Ports (clock is `clk`, reset is `resetn`, asynchronous and active-low; LW = max(1, $clog2(NUM_LAYERS))):
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  begin inference; honoured only in IDLE
- abort  in  1  return to IDLE next cycle from any state
- mm_start  out  NUM_LAYERS  one-hot, one-cycle start to MM engine i
- mm_done  in  NUM_LAYERS  completion from MM engine i
- relu_start  out  NUM_LAYERS  one-hot, one-cycle start to ReLU engine i
- relu_done  in  NUM_LAYERS  completion from ReLU engine i
- argmax_start  out  1  one-cycle start to argmax engine
- argmax_done  in  1  argmax completion
- argmax_index  in  CLASS_W  argmax result, valid with argmax_done
- busy  out  1  high in MM, RELU, ARGMAX
- done  out  1  one-cycle pulse on completion
- error  out  1  high while in ERROR
- result  out  CLASS_W  latched class index
- stage  out  3  current state encoding
- layer  out  LW  current layer index
- cycles  out  32  cycles from start acceptance to done

## Operation
- States and `stage` codes: IDLE=0, MM=1, RELU=2, ARGMAX=3, DONE=4, ERROR=5.
- IDLE + start:
  - go to MM with layer=0;
  - clear cycles;
  - result unchanged.
- Start pulses:
  - On the first cycle of every MM/RELU/ARGMAX stage entry, exactly one start bit is high: mm_start[layer], relu_start[layer] or argmax_start.
  - All start bits are registered outputs.
- Done sampling:
  - Only the done bit matching the current state and layer is sampled.
  - Sampling begins the cycle after the start pulse; a done coincident with the pulse is ignored.
  - Done bits of other layers/engines are ignored.
- MM + mm_done[layer]:
  - if RELU_MASK[layer], go to RELU (same layer);
  - else if layer == NUM_LAYERS-1, go to ARGMAX;
  - else go to MM with layer+1.
- RELU + relu_done[layer]: go to ARGMAX if last layer, else MM with layer+1.
- ARGMAX + argmax_done: result ← argmax_index; go to DONE.
- DONE: done=1 for one cycle; go to IDLE. Result holds until the next argmax_done.
- Watchdog:
  - The counter clears on every stage entry.
  - If it reaches TIMEOUT-1 without the expected done, go to ERROR.
  - layer and stage freeze the failing location; stage reads 5, and `layer` keeps the failing layer.
- ERROR: exits only via abort.
- abort:
  - takes priority over all transitions;
  - next state is IDLE, layer=0, no start pulse;
  - result and cycles hold.
- cycles: increments every cycle in MM/RELU/ARGMAX; saturates at 2^32-1.

## Timing
- Reset values: mm_start=0, relu_start=0, argmax_start=0, busy=0, done=0, error=0, result=0, stage=0, layer=0, cycles=0; state IDLE.
- Latencies:
  - start → mm_start[0] high: 1 cycle.
  - done input → next start pulse: 1 cycle.
  - argmax_done → done pulse: 1 cycle.
  - done → IDLE: 1 cycle, so the earliest restart is the cycle after done.
- start while busy is ignored.
- start and abort together in IDLE: abort wins; stay IDLE.
- Reset mid-inference: all outputs go to reset values asynchronously; an engine's late done after reset is ignored in IDLE.

## Structure
- Shared package `nn_pkg` holds:
  - the state enum/localparams (IDLE..ERROR);
  - STAGE_W=3;
  - default CLASS_W;
  - the layer-count limit.
- One natural sub-module: `stage_watchdog`, containing the cycle counter with clear/enable and a timeout flag, parametrised by TIMEOUT.
- The FSM and latency counter stay in the top.

## Test plan
- Default params, each engine answers 5 cycles after its start:
  - pulse order mm0, relu0, mm1, relu1, mm2, relu2, mm3, argmax;
  - argmax_index=7 → result=7, done for one cycle;
  - cycles=48 (8 stages × 6 cycles).
- RELU_MASK=4'b0000: no relu_start ever; the mm3 done is followed by argmax_start the next cycle.
- TIMEOUT=16, mm_done[2] never asserted:
  - error=1, stage=5 and layer=2 after 16 cycles in layer-2 MM;
  - stays there until abort, then IDLE.
- Abort during layer 1 RELU: IDLE next cycle; a subsequent relu_done[1] is ignored; the next start restarts at mm_start[0].
- Spurious mm_done[3] during layer 0 MM, plus mm_done[0] coincident with the mm_start[0] pulse: both are ignored; the stage advances only on a later mm_done[0].
- resetn low for 1 cycle during ARGMAX: all outputs go to 0 immediately and the FSM is in IDLE.
